// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : SPI transaction sequencer. It frames a 1..MAX_BYTES transfer
//             on top of a byte-level SPI engine through the getByte/BUSY/
//             RxData handshake. It adds an SS setup delay, an optional
//             inter-byte gap and an optional stall watchdog.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: SPI_XFER_TIMEOUT_EN
//    defined   : Init/Wait stall watchdog; aborts to Done with ERR=1
//    undefined : ERR tied low, Init/Wait wait indefinitely
// ----------------------------------------------------------------------------
//  Ports
//    CLK     in   system clock, all state updates on the falling edge
//    RST     in   asynchronous reset, active low
//    sndRec  in   start request (level, sampled in Idle)
//    LEN     in   byte count; 0 or >MAX_BYTES means MAX_BYTES
//    DIN     in   transmit data, MSB-aligned (top byte goes first)
//    BUSY    in   byte engine busy
//    RxData  in   last received byte, valid when BUSY falls
//    SS      out  slave select, active low
//    getByte out  byte transfer request to the engine
//    sndData out  byte presented to the engine
//    DOUT    out  received data, right-aligned, unused upper bytes zero
//    DONE    out  high while in Done
//    ERR     out  watchdog abort flag
// ============================================================================
module spi_xfer_ctrl #(
  parameter int MAX_BYTES   = 5,
  parameter int LEN_W       = 3,
  parameter int SETUP_CYC   = 1,
  parameter int GAP_CYC     = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sndRec,
  input  logic [LEN_W-1:0]       LEN,
  input  logic [8*MAX_BYTES-1:0] DIN,
  input  logic                   BUSY,
  input  logic [7:0]             RxData,
  output logic                   SS,
  output logic                   getByte,
  output logic [7:0]             sndData,
  output logic [8*MAX_BYTES-1:0] DOUT,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int c_DW      = 8 * MAX_BYTES;
  localparam int c_CNT_W   = $clog2(MAX_BYTES + 1);
  localparam int c_DLY_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_INIT  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_DW-1:0]      r_tx;
  logic [c_DW-1:0]      r_rx;
  logic [c_DW-1:0]      r_dout;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   r_len;
  logic [c_DLY_W-1:0]   r_dly;
  logic [c_CNT_W-1:0]   w_len_eff;
  logic [c_DW-1:0]      w_rx_next;
  logic                 w_last;
  logic                 w_wdog_hit;

  // Out-of-range lengths (0 or above MAX_BYTES) run a full-size transfer.
  assign w_len_eff = ((LEN == '0) || (LEN > LEN_W'(MAX_BYTES)))
                     ? c_CNT_W'(MAX_BYTES) : c_CNT_W'(LEN);

  assign w_rx_next = {r_rx[c_DW-9:0], RxData};
  assign w_last    = (r_cnt == r_len);

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_WD_W-1:0] r_wdog;
  logic              r_err;

  assign w_wdog_hit = ((r_state == S_INIT) || (r_state == S_WAIT)) &&
                      (r_wdog == c_WD_W'(TIMEOUT_CYC - 1));

  // Any state change clears the watchdog, so it restarts on every entry to
  // Init or Wait and only accumulates while the FSM sits in one of them.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_wdog <= '0;
    end else if (w_next != r_state) begin
      r_wdog <= '0;
    end else if ((r_state == S_INIT) || (r_state == S_WAIT)) begin
      r_wdog <= r_wdog + c_WD_W'(1);
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && sndRec) begin
      r_err <= 1'b0;
    end else if (w_wdog_hit) begin
      r_err <= 1'b1;
    end
  end

  assign ERR = r_err;
`else
  localparam int c_unused_timeout = TIMEOUT_CYC;

  assign w_wdog_hit = 1'b0;
  assign ERR        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next  = r_state;
    SS      = 1'b1;
    getByte = 1'b0;
    sndData = 8'h00;
    DONE    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sndRec) begin
          w_next = S_SETUP;
        end
      end

      S_SETUP: begin
        SS = 1'b0;
        if (r_dly == c_DLY_W'(SETUP_CYC - 1)) begin
          w_next = S_INIT;
        end
      end

      S_INIT: begin
        SS      = 1'b0;
        getByte = 1'b1;
        sndData = r_tx[c_DW-1 -: 8];
        if (BUSY) begin
          w_next = S_WAIT;
        end
      end

      S_WAIT: begin
        SS = 1'b0;
        if (!BUSY) begin
          w_next = S_CHECK;
        end
      end

      S_CHECK: begin
        SS = 1'b0;
        if (w_last) begin
          w_next = S_DONE;
        end else if (GAP_CYC > 0) begin
          w_next = S_GAP;
        end else begin
          w_next = S_INIT;
        end
      end

      S_GAP: begin
        SS = 1'b0;
        if (r_dly == c_DLY_W'(GAP_CYC - 1)) begin
          w_next = S_INIT;
        end
      end

      S_DONE: begin
        DONE = 1'b1;
        if (!sndRec) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Watchdog abort overrides the normal Init/Wait exits.
    if (w_wdog_hit) begin
      w_next = S_DONE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shift registers, byte counter, delay counter, DOUT
  // --------------------------------------------------------------------------
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_dout <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_dly  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx  <= DIN;
          r_rx  <= '0;
          r_cnt <= '0;
          r_len <= w_len_eff;
          r_dly <= '0;
        end

        S_SETUP: begin
          r_dly <= r_dly + c_DLY_W'(1);
        end

        S_INIT: begin
          if (BUSY && !w_wdog_hit) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        S_CHECK: begin
          r_rx  <= w_rx_next;
          r_tx  <= {r_tx[c_DW-9:0], 8'h00};
          r_dly <= '0;
          // DOUT takes the complete received word in one step, on the same
          // edge that enters Done, so it is never seen partially updated.
          if (w_last) begin
            r_dout <= w_rx_next;
          end
        end

        S_GAP: begin
          r_dly <= r_dly + c_DLY_W'(1);
        end

        default: begin
        end
      endcase
    end
  end

  assign DOUT = r_dout;

endmodule
`default_nettype wire
